instr_input_frontend: RTL and testbench



---
 rtl/instr_input_frontend.sv | 118 +++++++++++
 tb/tb_instr_input_frontend.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_input_frontend.sv
// Input-conditioning front end: synchronizes and debounces the power/send keys and the
// data switches, pulses power_toggle and offers captured switch words over valid/ready.
module instr_input_frontend #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_power_n,
    input  logic        key_send_n,
    input  logic [17:0] switches_raw,
    input  logic        cpu_ready,
    output logic        power_toggle,
    output logic        instr_valid,
    output logic [17:0] instr_word,
    output logic        overrun
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int KEY_POWER = 0;
    localparam int KEY_SEND  = 1;

    logic [1:0]       key_meta;
    logic [1:0]       key_sync;
    logic [17:0]      sw_meta;
    logic [17:0]      sw_sync;
    logic [1:0]       stable;
    logic [CNT_W-1:0] cnt [2];
    logic [1:0]       fall;
    logic             power_press;
    logic             send_press;
    logic [17:0]      send_sample;

    // Keys idle high (released) out of reset so a reset never looks like a press.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_meta <= 2'b11;
            key_sync <= 2'b11;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            key_meta <= {key_send_n, key_power_n};
            key_sync <= key_meta;
            sw_meta  <= switches_raw;
            sw_sync  <= sw_meta;
        end
    end

    // A press is the edge on which a debounced level is about to go 1 -> 0.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        fall = '0;
        for (int i = 0; i < 2; i++) begin
            fall[i] = stable[i] && !key_sync[i] && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (key_sync[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= key_sync[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Switches are sampled on the very edge the debounced send key falls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            power_press <= 1'b0;
            send_press  <= 1'b0;
            send_sample <= '0;
        end else begin
            power_press <= fall[KEY_POWER];
            send_press  <= fall[KEY_SEND];
            if (fall[KEY_SEND]) begin
                send_sample <= sw_sync;
            end
        end
    end

    // Power has priority: it aborts any pending word and swallows a simultaneous send.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            power_toggle <= 1'b0;
            instr_valid  <= 1'b0;
            instr_word   <= '0;
            overrun      <= 1'b0;
        end else begin
            power_toggle <= power_press;
            if (power_press) begin
                instr_valid <= 1'b0;
            end else if (send_press) begin
                if (!instr_valid || cpu_ready) begin
                    instr_word  <= send_sample;
                    instr_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (instr_valid && cpu_ready) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_input_frontend.sv
// Self-checking bench for instr_input_frontend with DEBOUNCE_CYCLES=4: table-driven send
// presses plus hand sequences for overrun, power abort, simultaneous presses and reset.
module tb_instr_input_frontend;

    localparam int DC = 4;
    localparam int CW = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_power_n = 1'b1;
    logic        key_send_n = 1'b1;
    logic [17:0] switches_raw = '0;
    logic        cpu_ready = 1'b0;
    logic        power_toggle;
    logic        instr_valid;
    logic [17:0] instr_word;
    logic        overrun;

    int n_checks = 0;
    int n_pass = 0;
    logic [17:0] exp_q[$];

    typedef struct {
        logic [17:0] sw;
        int          low;
        logic        exp_valid;
        logic [17:0] exp_word;
    } vec_t;

    vec_t vecs[5];

    instr_input_frontend #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_power_n(key_power_n),
        .key_send_n(key_send_n),
        .switches_raw(switches_raw),
        .cpu_ready(cpu_ready),
        .power_toggle(power_toggle),
        .instr_valid(instr_valid),
        .instr_word(instr_word),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A transfer completes on the coming edge; the word must be the oldest expected one.
    always @(negedge clk) begin
        if (!reset && instr_valid && cpu_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_transfer: got word 0x%0h with no word expected", instr_word);
            end else begin
                check("sb_transfer_word", 32'(instr_word), 32'(exp_q.pop_front()));
            end
        end
    end

    // Drives key_send_n low and checks the valid rises exactly DC+2 edges after FF1 sees it.
    task automatic send_latency(input string name, input logic [17:0] sw);
        key_send_n = 1'b0;
        exp_q.push_back(sw);
        repeat (DC + 2) tick();
        check({name, "_not_yet"}, 32'(instr_valid), 32'd0);
        tick();
        check({name, "_valid"}, 32'(instr_valid), 32'd1);
        check({name, "_word"}, 32'(instr_word), 32'(sw));
    endtask

    task automatic consume();
        cpu_ready = 1'b1;
        tick();
        cpu_ready = 1'b0;
    endtask

    task automatic load_switches(input logic [17:0] sw);
        switches_raw = sw;
        repeat (3) tick();
    endtask

    initial begin
        int bad;
        int pulses;

        vecs[0] = '{sw: 18'h0ABCD, low: 10, exp_valid: 1'b1, exp_word: 18'h0ABCD};
        vecs[1] = '{sw: 18'h15A3A, low: 3,  exp_valid: 1'b0, exp_word: 18'h0ABCD};
        vecs[2] = '{sw: 18'h3FFFF, low: 4,  exp_valid: 1'b1, exp_word: 18'h3FFFF};
        vecs[3] = '{sw: 18'h00000, low: 2,  exp_valid: 1'b0, exp_word: 18'h3FFFF};
        vecs[4] = '{sw: 18'h12345, low: 6,  exp_valid: 1'b1, exp_word: 18'h12345};

        // Reset values, then 50 idle cycles.
        #1;
        check("rst_outputs", {power_toggle, instr_valid, overrun, instr_word}, 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        bad = 0;
        repeat (50) begin
            tick();
            if (power_toggle || instr_valid || overrun || instr_word != 0) bad++;
        end
        check("idle_outputs", bad, 0);

        // Basic capture with latency; word held stable while cpu_ready=0.
        load_switches(18'h2A5C5);
        send_latency("lat", 18'h2A5C5);
        repeat (3) tick();
        key_send_n = 1'b1;
        bad = 0;
        repeat (20) begin
            tick();
            if (!instr_valid || instr_word != 18'h2A5C5) bad++;
        end
        check("hold_stable", bad, 0);
        consume();
        check("handshake_drop", 32'(instr_valid), 32'd0);
        check("handshake_word_kept", 32'(instr_word), 32'h2A5C5);
        repeat (10) tick();

        // Bounce: 3 low cycles then 1-cycle toggles must never be accepted.
        load_switches(18'h3C3C3);
        key_send_n = 1'b0;
        bad = 0;
        repeat (3) begin
            tick();
            if (instr_valid) bad++;
        end
        repeat (20) begin
            key_send_n = ~key_send_n;
            tick();
            if (instr_valid) bad++;
        end
        key_send_n = 1'b1;
        repeat (10) begin
            tick();
            if (instr_valid) bad++;
        end
        check("bounce_no_valid", bad, 0);
        load_switches(18'h0F0F0);
        send_latency("after_bounce", 18'h0F0F0);
        key_send_n = 1'b1;
        repeat (10) tick();
        consume();
        repeat (5) tick();

        // Table: press width vs DEBOUNCE_CYCLES.
        for (int i = 0; i < 5; i++) begin
            load_switches(vecs[i].sw);
            key_send_n = 1'b0;
            if (vecs[i].exp_valid) exp_q.push_back(vecs[i].sw);
            repeat (vecs[i].low) tick();
            key_send_n = 1'b1;
            repeat (10) tick();
            check($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_word", i), 32'(instr_word), 32'(vecs[i].exp_word));
            if (vecs[i].exp_valid) begin
                consume();
                check($sformatf("vec%0d_consumed", i), 32'(instr_valid), 32'd0);
            end
        end

        // Simultaneous power and send with a word pending: power wins, no overrun.
        load_switches(18'h0F00F);
        send_latency("sim_setup", 18'h0F00F);
        key_send_n = 1'b1;
        repeat (10) tick();
        load_switches(18'h000FF);
        key_send_n = 1'b0;
        key_power_n = 1'b0;
        repeat (DC + 3) tick();
        exp_q.pop_front();
        check("sim_toggle", 32'(power_toggle), 32'd1);
        check("sim_valid_cleared", 32'(instr_valid), 32'd0);
        check("sim_no_overrun", 32'(overrun), 32'd0);
        key_send_n = 1'b1;
        key_power_n = 1'b1;
        repeat (10) tick();
        check("sim_after", {instr_valid, overrun}, 32'd0);
        check("sim_word_kept", 32'(instr_word), 32'h0F00F);

        // Overrun: second press while pending and not ready.
        load_switches(18'h2A5C5);
        send_latency("ovr_setup", 18'h2A5C5);
        key_send_n = 1'b1;
        repeat (10) tick();
        load_switches(18'h00001);
        key_send_n = 1'b0;
        repeat (8) tick();
        key_send_n = 1'b1;
        repeat (10) tick();
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_word_unchanged", 32'(instr_word), 32'h2A5C5);
        check("ovr_still_valid", 32'(instr_valid), 32'd1);
        consume();
        check("ovr_transfer", 32'(instr_valid), 32'd0);
        check("ovr_sticky", 32'(overrun), 32'd1);

        // Transfer and new capture on the same edge: valid stays high with the new word.
        load_switches(18'h11111);
        send_latency("same_setup", 18'h11111);
        key_send_n = 1'b1;
        repeat (10) tick();
        load_switches(18'h22222);
        key_send_n = 1'b0;
        exp_q.push_back(18'h22222);
        repeat (DC + 2) tick();
        cpu_ready = 1'b1;
        tick();
        cpu_ready = 1'b0;
        check("same_edge_valid", 32'(instr_valid), 32'd1);
        check("same_edge_word", 32'(instr_word), 32'h22222);
        key_send_n = 1'b1;
        repeat (10) tick();
        consume();

        // Power press aborts a pending word; one pulse however long the key is held.
        load_switches(18'h33333);
        send_latency("pwr_setup", 18'h33333);
        key_send_n = 1'b1;
        repeat (10) tick();
        key_power_n = 1'b0;
        repeat (DC + 2) tick();
        check("pwr_before", {power_toggle, instr_valid}, 32'd1);
        tick();
        exp_q.pop_front();
        check("pwr_pulse", 32'(power_toggle), 32'd1);
        check("pwr_abort", 32'(instr_valid), 32'd0);
        pulses = 0;
        repeat (100) begin
            tick();
            if (power_toggle) pulses++;
        end
        check("pwr_single_pulse", pulses, 0);
        key_power_n = 1'b1;
        repeat (10) tick();

        // Reset mid-debounce (cnt=2) with a word pending, key held through deassert.
        load_switches(18'h0ACE1);
        send_latency("rst_setup", 18'h0ACE1);
        key_send_n = 1'b1;
        repeat (10) tick();
        load_switches(18'h15555);
        key_send_n = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        check("midrst_outputs", {power_toggle, instr_valid, overrun, instr_word}, 32'd0);
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b0;
        send_latency("midrst_repress", 18'h15555);
        key_send_n = 1'b1;
        repeat (10) tick();
        consume();
        repeat (3) tick();
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
